// File: rtl/pow_pkg.sv
// Shared state encoding for the square-and-multiply exponent FSMD.
package pow_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/pow_step.sv
// One square-and-multiply step: conditional accumulate plus base squaring,
// with overflow reported from the upper halves of both full-width products.
module pow_step #(
  parameter int R_W = 16
) (
  input  logic [R_W-1:0] acc,
  input  logic [R_W-1:0] base,
  input  logic           exp_bit0,
  input  logic           exp_more,
  output logic [R_W-1:0] acc_nxt,
  output logic [R_W-1:0] base_nxt,
  output logic           ovf_nxt
);
  logic [2*R_W-1:0] acc_prod;
  logic [2*R_W-1:0] base_prod;

  always_comb begin
    acc_prod  = {{R_W{1'b0}}, acc} * {{R_W{1'b0}}, base};
    base_prod = {{R_W{1'b0}}, base} * {{R_W{1'b0}}, base};
    acc_nxt   = acc;
    ovf_nxt   = 1'b0;
    base_nxt  = base_prod[R_W-1:0];
    if (exp_bit0) begin
      acc_nxt = acc_prod[R_W-1:0];
      ovf_nxt = |acc_prod[2*R_W-1:R_W];
    end
    // A squared base that is never multiplied in again cannot corrupt the result.
    if (exp_more) begin
      ovf_nxt = ovf_nxt | (|base_prod[2*R_W-1:R_W]);
    end
  end
endmodule

// File: rtl/pow_fsmd.sv
// Exponent FSMD: output_reg = a_i ** n_i by square-and-multiply, one exponent
// bit per cycle, with sticky per-operation overflow and optional saturation.
module pow_fsmd
  import pow_pkg::*;
#(
  parameter int A_W      = 8,
  parameter int N_W      = 8,
  parameter int R_W      = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go_i,
  input  logic [A_W-1:0] a_i,
  input  logic [N_W-1:0] n_i,
  output logic [R_W-1:0] output_reg,
  output logic           ovf,
  output logic           busy,
  output logic           sig_done
);
  state_t         state_q, state_d;
  logic [R_W-1:0] acc_q, acc_d;
  logic [R_W-1:0] base_q, base_d;
  logic [N_W-1:0] exp_q, exp_d;
  logic           ovf_acc_q, ovf_acc_d;
  logic [R_W-1:0] res_q, res_d;
  logic           ovf_q, ovf_d;

  logic [R_W-1:0] step_acc;
  logic [R_W-1:0] step_base;
  logic           step_ovf;
  logic           exp_more;

  assign exp_more = (exp_q >> 1) != '0;

  pow_step #(.R_W(R_W)) u_step (
    .acc      (acc_q),
    .base     (base_q),
    .exp_bit0 (exp_q[0]),
    .exp_more (exp_more),
    .acc_nxt  (step_acc),
    .base_nxt (step_base),
    .ovf_nxt  (step_ovf)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    base_d    = base_q;
    exp_d     = exp_q;
    ovf_acc_d = ovf_acc_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (go_i) begin
          base_d    = R_W'(a_i);
          exp_d     = n_i;
          acc_d     = R_W'(1);
          ovf_acc_d = 1'b0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (exp_q == '0) begin
          res_d   = (SATURATE && ovf_acc_q) ? '1 : acc_q;
          ovf_d   = ovf_acc_q;
          state_d = S_DONE;
        end else begin
          acc_d     = step_acc;
          base_d    = step_base;
          ovf_acc_d = ovf_acc_q | step_ovf;
          exp_d     = exp_q >> 1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      base_q    <= '0;
      exp_q     <= '0;
      ovf_acc_q <= 1'b0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      base_q    <= base_d;
      exp_q     <= exp_d;
      ovf_acc_q <= ovf_acc_d;
      res_q     <= res_d;
      ovf_q     <= ovf_d;
    end
  end

  assign output_reg = res_q;
  assign ovf        = ovf_q;
  assign busy       = (state_q == S_RUN) || (state_q == S_DONE);
  assign sig_done   = (state_q == S_DONE);
endmodule

// File: tb/tb_pow_fsmd.sv
// Randomised bench for pow_fsmd against a repeated-multiplication reference,
// running a saturating and a wrapping instance side by side.
module tb_pow_fsmd;
  localparam int A_W = 8;
  localparam int N_W = 8;
  localparam int R_W = 16;

  logic           clk;
  logic           rst;
  logic           go_i;
  logic [A_W-1:0] a_i;
  logic [N_W-1:0] n_i;
  logic [R_W-1:0] out_s, out_w;
  logic           ovf_s, ovf_w;
  logic           busy_s, busy_w;
  logic           done_s, done_w;

  int checks = 0;
  int errors = 0;

  pow_fsmd #(.A_W(A_W), .N_W(N_W), .R_W(R_W), .SATURATE(1'b1)) u_dut_sat (
    .clk(clk), .rst(rst), .go_i(go_i), .a_i(a_i), .n_i(n_i),
    .output_reg(out_s), .ovf(ovf_s), .busy(busy_s), .sig_done(done_s)
  );

  pow_fsmd #(.A_W(A_W), .N_W(N_W), .R_W(R_W), .SATURATE(1'b0)) u_dut_wrap (
    .clk(clk), .rst(rst), .go_i(go_i), .a_i(a_i), .n_i(n_i),
    .output_reg(out_w), .ovf(ovf_w), .busy(busy_w), .sig_done(done_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // True power a**n: low 16 bits plus whether the exact value ever reached 2**16.
  task automatic ref_pow(input int a, input int n, output logic [15:0] low, output bit big);
    longint p;
    p   = 1;
    big = 1'b0;
    for (int i = 0; i < n; i++) begin
      p = p * a;
      if (p >= 65536) begin
        big = 1'b1;
        p   = p % 65536;
      end
    end
    low = p[15:0];
  endtask

  function automatic int bitlen(input int n);
    int b;
    b = 0;
    while (n > 0) begin
      b++;
      n = n >> 1;
    end
    return b;
  endfunction

  task automatic run_op(input int a, input int n, input bit pulse_mid, input string tag);
    logic [15:0] low;
    bit          big;
    int          edges;
    bit          seen;
    bit          busy_ok;
    ref_pow(a, n, low, big);
    @(negedge clk);
    a_i  = A_W'(a);
    n_i  = N_W'(n);
    go_i = 1'b1;
    @(posedge clk);
    #1;
    go_i    = 1'b0;
    a_i     = A_W'($urandom);
    n_i     = N_W'($urandom);
    edges   = 1;
    seen    = 1'b0;
    busy_ok = busy_s && busy_w;
    while (!seen && edges < 300) begin
      @(posedge clk);
      #1;
      edges++;
      if (go_i) go_i = 1'b0;
      if (pulse_mid && edges == 2) begin
        a_i  = 8'd7;
        n_i  = 8'd3;
        go_i = 1'b1;
      end
      if (!busy_s || !busy_w) busy_ok = 1'b0;
      if (done_s) seen = 1'b1;
    end
    go_i = 1'b0;
    chk({tag, " latency"}, 32'(edges), 32'(bitlen(n) + 2));
    chk({tag, " busy"}, 32'(busy_ok), 32'd1);
    chk({tag, " res_sat"}, 32'(out_s), big ? 32'hFFFF : 32'(low));
    chk({tag, " ovf_sat"}, 32'(ovf_s), 32'(big));
    chk({tag, " res_wrap"}, 32'(out_w), 32'(low));
    chk({tag, " ovf_wrap"}, 32'(ovf_w), 32'(big));
    chk({tag, " done_wrap"}, 32'(done_w), 32'd1);
    @(posedge clk);
    #1;
    chk({tag, " done_width"}, 32'(done_s), 32'd0);
    chk({tag, " idle_busy"}, 32'(busy_s), 32'd0);
    chk({tag, " res_held"}, 32'(out_w), 32'(low));
    chk({tag, " ovf_held"}, 32'(ovf_s), 32'(big));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation timed out");
  end

  initial begin
    bit any_done;
    rst  = 1'b0;
    go_i = 1'b0;
    a_i  = '0;
    n_i  = '0;
    #1;
    chk("rst out", 32'(out_s), 32'd0);
    chk("rst ovf", 32'(ovf_s), 32'd0);
    chk("rst busy", 32'(busy_s), 32'd0);
    chk("rst done", 32'(done_s), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    run_op(2, 5, 1'b0, "a2n5");
    run_op(3, 0, 1'b0, "a3n0");
    run_op(0, 0, 1'b0, "a0n0");
    run_op(0, 7, 1'b0, "a0n7");
    run_op(255, 2, 1'b0, "a255n2");
    run_op(2, 16, 1'b0, "a2n16");
    run_op(1, 255, 1'b0, "a1n255");
    run_op(255, 255, 1'b0, "a255n255");
    run_op(2, 15, 1'b0, "a2n15");
    run_op(2, 5, 1'b1, "go_in_run");

    // Abort a long operation with an asynchronous reset pulse.
    @(negedge clk);
    a_i  = 8'd3;
    n_i  = 8'd200;
    go_i = 1'b1;
    @(posedge clk);
    #1;
    go_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort out", 32'(out_s), 32'd0);
    chk("abort out_w", 32'(out_w), 32'd0);
    chk("abort ovf", 32'(ovf_s), 32'd0);
    chk("abort busy", 32'(busy_s), 32'd0);
    chk("abort done", 32'(done_s), 32'd0);
    @(negedge clk);
    rst      = 1'b1;
    any_done = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done_s || done_w || busy_s) any_done = 1'b1;
    end
    chk("abort quiet", 32'(any_done), 32'd0);
    run_op(3, 4, 1'b0, "after_abort");

    for (int i = 0; i < 40; i++) begin
      int a;
      int n;
      a = int'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) n = int'($urandom_range(0, 255));
      else n = int'($urandom_range(0, 20));
      if ($urandom_range(0, 4) == 0) a = int'($urandom_range(0, 3));
      run_op(a, n, 1'b0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
